spi_master_mc: RTL



---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_clk_gen.sv | 53 +++++
 rtl/spi_master_mc.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-chip-select SPI master.
//   spi_state_e  : controller states
//   spi_mode_t   : per-burst SPI mode captured on the first word
//   cnt_w()      : counter width able to hold 0..n-1 without wrapping
//   cs_off_level(): inactive chip-select level for a given polarity
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    // Width for a counter whose largest value is n-1; never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic cs_off_level(input int unsigned polar);
        return (polar != 0) ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: while en is high, toggles SCK every P_CLK_DIV cycles.
//   clk_100, s_rst : clock, synchronous active-low reset
//   en             : run the divider (held low outside the shift phase)
//   cpol           : idle level of SCK
//   lead_stb_c     : this cycle's clock edge produces a leading SCK edge
//   trail_stb_c    : this cycle's clock edge produces a trailing SCK edge
//   sck            : registered serial clock
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned P_CLK_DIV = 1
) (
    input  logic clk_100,
    input  logic s_rst,
    input  logic en,
    input  logic cpol,
    output logic lead_stb_c,
    output logic trail_stb_c,
    output logic sck
);

    localparam int unsigned DIV_CNT_W = cnt_w(P_CLK_DIV);
    localparam logic [DIV_CNT_W-1:0] DIV_END = DIV_CNT_W'(P_CLK_DIV - 1);

    logic [DIV_CNT_W-1:0] div_cnt;
    logic                 phase;   // 0 = SCK at idle level, 1 = after a leading edge
    logic                 tick_c;

    always_comb begin
        tick_c      = en && (div_cnt == DIV_END);
        lead_stb_c  = tick_c && !phase;
        trail_stb_c = tick_c && phase;
    end

    always_ff @(posedge clk_100) begin
        if (!s_rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            sck     <= cpol;
        end else if (tick_c) begin
            div_cnt <= '0;
            phase   <= ~phase;
            sck     <= cpol ^ ~phase;
        end else begin
            div_cnt <= div_cnt + DIV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// Full-duplex SPI master with runtime mode, P_CS_NUM chip selects and
// multi-word bursts (CS held between words of a burst).
//   s_valid/s_ready/s_data/s_cs_sel/s_last : word input handshake
//   cpol/cpha/lsb_first                    : mode, captured on a burst's first word
//   m_valid/m_data                         : received word, one-cycle pulse
//   busy                                   : burst in progress
//   SCK/CS/MOSI/MISO                       : SPI bus
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_CLK_DIV    = 1,
    parameter int unsigned P_CS_NUM     = 4,
    parameter int unsigned P_CS_POLAR   = 1,
    parameter int unsigned P_CS_GAP     = 2
) (
    input  logic                        clk_100,
    input  logic                        s_rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [P_DATA_WIDTH-1:0]     s_data,
    input  logic [cnt_w(P_CS_NUM)-1:0]  s_cs_sel,
    input  logic                        s_last,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic                        lsb_first,
    output logic                        m_valid,
    output logic [P_DATA_WIDTH-1:0]     m_data,
    output logic                        busy,
    output logic                        SCK,
    output logic [P_CS_NUM-1:0]         CS,
    output logic                        MOSI,
    input  logic                        MISO
);

    localparam int unsigned CS_SEL_W  = cnt_w(P_CS_NUM);
    localparam int unsigned BIT_CNT_W = cnt_w(P_DATA_WIDTH);
    localparam int unsigned WAIT_W    = cnt_w((P_CLK_DIV > P_CS_GAP) ? P_CLK_DIV : P_CS_GAP);
    localparam logic        CS_OFF    = cs_off_level(P_CS_POLAR);

    localparam logic [BIT_CNT_W-1:0] BIT_END    = BIT_CNT_W'(P_DATA_WIDTH - 1);
    localparam logic [WAIT_W-1:0]    WAIT_D_END = WAIT_W'(P_CLK_DIV - 1);
    localparam logic [WAIT_W-1:0]    WAIT_G_END = WAIT_W'(P_CS_GAP - 1);

    spi_state_e              state;
    spi_mode_t               mode;
    logic                    last_q;
    logic                    hold_first;
    logic [P_DATA_WIDTH-1:0] tx_sr;      // bits still to be driven, next one at the front
    logic [P_DATA_WIDTH-1:0] rx_sr;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [WAIT_W-1:0]       wait_cnt;   // SETUP / HOLD / GAP duration

    logic                    ld_lsb, ld_cpha, ld_first, tx_first, sck_pol;
    logic [P_DATA_WIDTH-1:0] ld_rest, tx_rest, rx_next;
    logic [P_CS_NUM-1:0]     cs_dec;
    logic                    lead_stb_c, trail_stb_c;

    // Mode comes from the live inputs on a burst's first word, from the latch afterwards.
    always_comb begin
        ld_lsb   = (state == ST_IDLE) ? lsb_first : mode.lsb_first;
        ld_cpha  = (state == ST_IDLE) ? cpha : mode.cpha;
        sck_pol  = (state == ST_IDLE) ? cpol : mode.cpol;
        ld_first = ld_lsb ? s_data[0] : s_data[P_DATA_WIDTH-1];
        ld_rest  = ld_lsb ? (s_data >> 1) : (s_data << 1);
        tx_first = mode.lsb_first ? tx_sr[0] : tx_sr[P_DATA_WIDTH-1];
        tx_rest  = mode.lsb_first ? (tx_sr >> 1) : (tx_sr << 1);
        rx_next  = mode.lsb_first ? {MISO, rx_sr[P_DATA_WIDTH-1:1]}
                                  : {rx_sr[P_DATA_WIDTH-2:0], MISO};
        // Out-of-range selects leave every line inactive.
        cs_dec = {P_CS_NUM{CS_OFF}};
        for (int i = 0; i < int'(P_CS_NUM); i++) begin
            if (s_cs_sel == CS_SEL_W'(i)) begin
                cs_dec[i] = ~CS_OFF;
            end
        end
    end

    spi_clk_gen #(
        .P_CLK_DIV (P_CLK_DIV)
    ) u_clk_gen (
        .clk_100     (clk_100),
        .s_rst       (s_rst),
        .en          (state == ST_SHIFT),
        .cpol        (sck_pol),
        .lead_stb_c  (lead_stb_c),
        .trail_stb_c (trail_stb_c),
        .sck         (SCK)
    );

    // Controller FSM with registered outputs.
    always_ff @(posedge clk_100) begin
        if (!s_rst) begin
            state      <= ST_IDLE;
            mode       <= '0;
            last_q     <= 1'b0;
            hold_first <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            busy       <= 1'b0;
            CS         <= {P_CS_NUM{CS_OFF}};
            MOSI       <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        mode.cpol      <= cpol;
                        mode.cpha      <= cpha;
                        mode.lsb_first <= lsb_first;
                        CS             <= cs_dec;
                        busy           <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (wait_cnt == WAIT_D_END) begin
                        wait_cnt <= '0;
                        state    <= ST_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (lead_stb_c) begin
                        if (mode.cpha) begin
                            MOSI  <= tx_first;
                            tx_sr <= tx_rest;
                        end else begin
                            rx_sr <= rx_next;
                        end
                    end
                    if (trail_stb_c) begin
                        if (mode.cpha) begin
                            rx_sr <= rx_next;
                        end else if (bit_cnt != BIT_END) begin
                            MOSI  <= tx_first;
                            tx_sr <= tx_rest;
                        end
                        if (bit_cnt == BIT_END) begin
                            wait_cnt   <= '0;
                            hold_first <= 1'b1;
                            state      <= ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_first) begin
                        m_valid    <= 1'b1;
                        m_data     <= rx_sr;
                        hold_first <= 1'b0;
                    end
                    if (wait_cnt != WAIT_D_END) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end else if (last_q) begin
                        CS       <= {P_CS_NUM{CS_OFF}};
                        wait_cnt <= '0;
                        state    <= ST_GAP;
                    end else if (s_valid && s_ready) begin
                        state <= ST_SHIFT;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (wait_cnt == WAIT_G_END) begin
                        busy    <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Word load is common to a burst's first word (IDLE) and follow-on words (HOLD).
            if (s_valid && s_ready) begin
                s_ready <= 1'b0;
                last_q  <= s_last;
                bit_cnt <= '0;
                if (ld_cpha) begin
                    tx_sr <= s_data;
                end else begin
                    MOSI  <= ld_first;
                    tx_sr <= ld_rest;
                end
            end
        end
    end

endmodule
